// File: rtl/pwm_ctrl_pkg.sv
// Shared constants for the PWM timer controller: register map, CTRL/STATUS
// bit positions, FSM state encoding and the reset period.
package pwm_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_ONESHOT   = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam int unsigned STAT_WRAP    = 0;
  localparam int unsigned STAT_RUNNING = 1;

  localparam logic [15:0] RESET_PERIOD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable prescaler: tick is high one cycle out of every presc+1.
// clr restarts the division so the first tick lands presc cycles later.
module pwm_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] div_q;

  assign tick = (div_q == presc);

  // Divider counter; restarts on clear or after each tick.
  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timer controller: bus-programmed shadow PERIOD/DUTY that commit to the
// external period register only at LOAD and counter wrap, plus counter,
// registered PWM output and level wrap interrupt.
// Optional build macro PWM_PRESCALE_EN adds a CTRL[15:8] clock prescaler.
module pwm_timer_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [1:0]       bus_addr,
  input  logic [15:0]      bus_wdata,
  output logic [15:0]      bus_rdata,
  output logic [CNT_W-1:0] pr_next,
  input  logic [CNT_W-1:0] pr_q,
  output logic [CNT_W-1:0] cnt,
  output logic             pwm_out,
  output logic             irq
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CNT_W-1:0] period_sh_q, duty_sh_q;
  logic             en_q, oneshot_q, irq_en_q, wrap_q;
  logic             tick, wrap_evt;
  logic             wr_ctrl, wr_period, wr_duty, wr_status;
  logic [15:0]      ctrl_rd, status_rd, rd_mux;

  assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_period = bus_we && (bus_addr == ADDR_PERIOD);
  assign wr_duty   = bus_we && (bus_addr == ADDR_DUTY);
  assign wr_status = bus_we && (bus_addr == ADDR_STATUS);

`ifdef PWM_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic               presc_clr;

  // Prescale value lives in CTRL[15:8].
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (wr_ctrl) begin
      presc_q <= bus_wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  // Outside RUN covers IDLE and LOAD; every wrap restarts the division too.
  assign presc_clr = (state_q != ST_RUN) || wrap_evt;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (presc_clr),
    .presc (presc_q),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Next-state, next-count and duty commit; EN low beats a pending wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt;
    duty_act_d = duty_act_q;
    wrap_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d      = '0;
        duty_act_d = duty_sh_q;
        state_d    = en_q ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!en_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt == pr_q) begin
            wrap_evt   = 1'b1;
            cnt_d      = '0;
            duty_act_d = duty_sh_q;
            if (oneshot_q) state_d = ST_DONE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        cnt_d = '0;
        if (!en_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Period register input: hold unless committing the shadow period.
  always_comb begin
    pr_next = pr_q;
    if (!rst && ((state_q == ST_LOAD) || wrap_evt)) pr_next = period_sh_q;
  end

  // FSM, counter and PWM registers; pwm_out is built from next-cycle values
  // so it lines up with cnt instead of trailing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt        <= '0;
      duty_act_q <= '0;
      pwm_out    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt        <= cnt_d;
      duty_act_q <= duty_act_d;
      pwm_out    <= (state_d == ST_RUN) && (cnt_d < duty_act_d);
    end
  end

  // Bus-writable control, shadow registers and sticky WRAP (set wins on W1C).
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      oneshot_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      period_sh_q <= CNT_W'(RESET_PERIOD);
      duty_sh_q   <= '0;
      wrap_q      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q      <= bus_wdata[CTRL_EN];
        oneshot_q <= bus_wdata[CTRL_ONESHOT];
        irq_en_q  <= bus_wdata[CTRL_IRQ_EN];
      end
      if (wr_period) period_sh_q <= bus_wdata[CNT_W-1:0];
      if (wr_duty)   duty_sh_q   <= bus_wdata[CNT_W-1:0];
      if (wrap_evt) begin
        wrap_q <= 1'b1;
      end else if (wr_status && bus_wdata[STAT_WRAP]) begin
        wrap_q <= 1'b0;
      end
    end
  end

  // Read views of CTRL and STATUS; unimplemented bits read zero.
  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_EN]      = en_q;
    ctrl_rd[CTRL_ONESHOT] = oneshot_q;
    ctrl_rd[CTRL_IRQ_EN]  = irq_en_q;
`ifdef PWM_PRESCALE_EN
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
`else
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = '0;
`endif
    status_rd               = '0;
    status_rd[STAT_WRAP]    = wrap_q;
    status_rd[STAT_RUNNING] = (state_q == ST_RUN);
  end

  // Register read mux; shadow values, not the active ones, are returned.
  always_comb begin
    case (bus_addr)
      ADDR_CTRL:   rd_mux = ctrl_rd;
      ADDR_PERIOD: rd_mux = 16'(period_sh_q);
      ADDR_DUTY:   rd_mux = 16'(duty_sh_q);
      default:     rd_mux = status_rd;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      bus_rdata <= rd_mux;
    end
  end

  assign irq = wrap_q & irq_en_q;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Scoreboard bench for pwm_timer_ctrl with an external period register.
// Stimulus pushes (cycle, signal, expected) entries; a negedge monitor pops
// and compares entries due in the current cycle.
module tb_pwm_timer_ctrl;

  localparam int unsigned CNT_W = 16;

`ifdef PWM_PRESCALE_EN
  localparam bit PRESC_BUILD = 1'b1;
`else
  localparam bit PRESC_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bus_we = 1'b0;
  logic             bus_re = 1'b0;
  logic [1:0]       bus_addr = 2'd0;
  logic [15:0]      bus_wdata = '0;
  logic [15:0]      bus_rdata;
  logic [CNT_W-1:0] pr_next, pr_q, cnt;
  logic             pwm_out, irq;

  pwm_timer_ctrl #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .pr_next   (pr_next),
    .pr_q      (pr_q),
    .cnt       (cnt),
    .pwm_out   (pwm_out),
    .irq       (irq)
  );

  // External period register
  always @(posedge clk) begin
    if (rst) pr_q <= 16'hFFFF;
    else     pr_q <= pr_next;
  end

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {S_RDATA, S_CNT, S_PWM, S_IRQ, S_PRNEXT, S_PRQ} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    failures = 0;
  bit    drain_timeout = 1'b0;

  function automatic logic [15:0] sample(sig_e s);
    case (s)
      S_RDATA:  return bus_rdata;
      S_CNT:    return cnt;
      S_PWM:    return {15'd0, pwm_out};
      S_IRQ:    return {15'd0, irq};
      S_PRNEXT: return pr_next;
      default:  return pr_q;
    endcase
  endfunction

  // Monitor: compare every entry due this cycle; stale entries are failures.
  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sample(sb[i].sig);
        checks++;
        if (act !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d missed sample got=none expected=%h", sb[i].name, sb[i].cyc, sb[i].exp);
        sb.delete(i);
      end
    end
    if (drain_timeout && sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
      sb.delete();
    end
  end

  task automatic step(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int unsigned d, sig_e s, logic [15:0] e, string nm);
    item_t it;
    it.cyc  = cyc + d;
    it.sig  = s;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    step(1);
    bus_we = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, logic [15:0] e, string nm);
    bus_re   = 1'b1;
    bus_addr = a;
    expect_at(1, S_RDATA, e, nm);
    step(1);
    bus_re = 1'b0;
  endtask

  initial begin
    // Reset and register defaults
    step(3);
    rst = 1'b0;
    expect_at(0, S_CNT, 16'd0, "rst_cnt");
    expect_at(0, S_PWM, 16'd0, "rst_pwm");
    expect_at(0, S_IRQ, 16'd0, "rst_irq");
    expect_at(0, S_PRNEXT, 16'hFFFF, "rst_pr_next");
    rd(2'd0, 16'h0000, "rst_ctrl");
    rd(2'd1, 16'hFFFF, "rst_period");
    rd(2'd2, 16'h0000, "rst_duty");
    rd(2'd3, 16'h0000, "rst_status");

    // PERIOD=4 DUTY=2, EN|IRQ_EN
    wr(2'd1, 16'd4);
    wr(2'd2, 16'd2);
    wr(2'd0, 16'h0005);
    expect_at(1, S_PRNEXT, 16'd4, "load_pr_next");
    for (int unsigned i = 0; i < 10; i++) begin
      expect_at(2 + i, S_CNT, 16'(i % 5), "run_cnt");
      expect_at(2 + i, S_PWM, ((i % 5) < 2) ? 16'd1 : 16'd0, "run_pwm");
    end
    expect_at(6, S_IRQ, 16'd0, "irq_before_wrap");
    expect_at(7, S_IRQ, 16'd1, "irq_after_wrap");
    step(12);
    rd(2'd3, 16'h0003, "status_run_wrap");
    wr(2'd3, 16'h0001);
    expect_at(0, S_IRQ, 16'd0, "irq_w1c");
    rd(2'd3, 16'h0002, "status_after_w1c");

    // PERIOD=9 written mid-period (cnt=2) commits at the next wrap
    step(4);
    wr(2'd1, 16'd9);
    expect_at(0, S_CNT, 16'd3, "mid_cnt3");
    expect_at(1, S_CNT, 16'd4, "mid_cnt4");
    expect_at(1, S_PRQ, 16'd4, "mid_prq_old");
    expect_at(1, S_PRNEXT, 16'd9, "wrap_pr_next");
    expect_at(2, S_PRQ, 16'd9, "prq_new");
    expect_at(2, S_CNT, 16'd0, "new_cnt0");
    expect_at(11, S_CNT, 16'd9, "new_cnt9");
    expect_at(11, S_PWM, 16'd0, "new_pwm_low");
    expect_at(12, S_CNT, 16'd0, "new_wrap");
    step(13);
    wr(2'd0, 16'h0000);
    expect_at(1, S_CNT, 16'd0, "disable_cnt");
    step(1);
    rd(2'd3, 16'h0001, "status_idle");
    wr(2'd3, 16'h0001);

    // One-shot, PERIOD=3
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h0003);
    for (int unsigned i = 0; i < 4; i++) expect_at(2 + i, S_CNT, 16'(i), "os_cnt");
    expect_at(6, S_CNT, 16'd0, "os_done_cnt");
    expect_at(6, S_PWM, 16'd0, "os_done_pwm");
    expect_at(8, S_CNT, 16'd0, "os_done_hold");
    step(7);
    expect_at(0, S_IRQ, 16'd0, "os_irq_masked");
    rd(2'd3, 16'h0001, "os_status_done");
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0003);
    expect_at(3, S_CNT, 16'd1, "os2_cnt1");
    expect_at(6, S_CNT, 16'd0, "os2_done_cnt");
    step(3);
    rd(2'd3, 16'h0002, "os2_status_run");
    step(3);
    rd(2'd3, 16'h0001, "os2_status_done");
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);

    // DUTY=0 stays low
    wr(2'd2, 16'd0);
    wr(2'd1, 16'd5);
    wr(2'd0, 16'h0001);
    for (int unsigned i = 0; i < 7; i++) expect_at(2 + i, S_PWM, 16'd0, "pwm_duty0");
    expect_at(7, S_CNT, 16'd5, "p5_cnt5");
    expect_at(8, S_CNT, 16'd0, "p5_wrap");
    step(9);
    wr(2'd0, 16'h0000);
    step(2);

    // DUTY=6 > PERIOD=5 stays high
    wr(2'd2, 16'd6);
    wr(2'd0, 16'h0001);
    for (int unsigned i = 0; i < 12; i++) expect_at(2 + i, S_PWM, 16'd1, "pwm_duty_gt");
    expect_at(7, S_CNT, 16'd5, "dgt_cnt5");
    step(14);
    wr(2'd0, 16'h0000);
    step(2);

    // PERIOD=0 wraps every cycle; W1C on a wrap cycle loses to the set
    wr(2'd1, 16'd0);
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0001);
    for (int unsigned i = 0; i < 4; i++) expect_at(2 + i, S_CNT, 16'd0, "p0_cnt");
    expect_at(3, S_PWM, 16'd1, "p0_pwm");
    expect_at(4, S_PRNEXT, 16'd0, "p0_pr_next");
    step(4);
    wr(2'd3, 16'h0001);
    rd(2'd3, 16'h0003, "w1c_on_wrap");
    wr(2'd0, 16'h0000);
    step(2);
    wr(2'd3, 16'h0001);

    // Prescaler field: P=2 divides by 3 when built in, else ignored
    wr(2'd1, 16'd20);
    wr(2'd0, 16'h0201);
    rd(2'd0, PRESC_BUILD ? 16'h0201 : 16'h0001, "ctrl_presc_rd");
    for (int unsigned i = 0; i < 7; i++)
      expect_at(1 + i, S_CNT, PRESC_BUILD ? 16'(i / 3) : 16'(i), "presc_cnt");
    step(8);
    wr(2'd0, 16'h0000);
    step(2);

    // Reset mid-run at cnt=7
    wr(2'd2, 16'd10);
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0005);
    expect_at(9, S_CNT, 16'd7, "pre_rst_cnt");
    expect_at(9, S_PWM, 16'd1, "pre_rst_pwm");
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_at(0, S_CNT, 16'd0, "mrst_cnt");
    expect_at(0, S_PWM, 16'd0, "mrst_pwm");
    expect_at(0, S_IRQ, 16'd0, "mrst_irq");
    expect_at(0, S_PRQ, 16'hFFFF, "mrst_prq");
    expect_at(0, S_PRNEXT, 16'hFFFF, "mrst_pr_next");
    expect_at(5, S_IRQ, 16'd0, "mrst_irq_later");
    rd(2'd0, 16'h0000, "mrst_ctrl");
    rd(2'd1, 16'hFFFF, "mrst_period");
    rd(2'd2, 16'h0000, "mrst_duty");
    rd(2'd3, 16'h0000, "mrst_status");

    // Drain scoreboard with a bound
    for (int unsigned t = 0; t < 100 && sb.size() != 0; t++) step(1);
    if (sb.size() != 0) drain_timeout = 1'b1;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
